// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
//
// SPI mode-0 responder that runs entirely in the system clock domain. The
// external sclk, ss and MOSI are brought in through flip-flop synchronizers.
// Edges are found by comparing the last synchronizer stage with a one-cycle
// delayed copy. WIDTH-bit words are shifted MSB first in both directions.
//
// On-chip logic supplies the next outgoing word through a one-word transmit
// buffer with a valid/ready handshake. Each complete incoming word is
// presented on rx_data, together with a one-cycle rx_valid strobe.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   sclk         in   SPI clock from the master (asynchronous, CPOL=0/CPHA=0)
//   ss           in   active-low slave select (asynchronous)
//   MOSI         in   master-out data (asynchronous)
//   MISO         out  slave-out data, 0 while no frame is active
//   tx_data      in   word to send
//   tx_valid     in   tx_data is valid
//   tx_ready     out  transmit buffer empty; accepts tx_data on tx_valid
//   rx_data      out  last complete received word
//   rx_valid     out  one-cycle strobe, rx_data updated this cycle
//   busy         out  frame active
//   tx_underrun  out  one-cycle strobe, IDLE_FILL loaded because buffer empty
//   frame_error  out  one-cycle strobe, ss rose with a partial word
//
// Master timing assumed: sclk high and low phases each >= SYNC_STAGES+2
// clocks, and the first sclk rise >= SYNC_STAGES+3 clocks after ss falls.
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module spi_slave_sync #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] IDLE_FILL   = 8'hFF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sclk,
   input  logic             ss,
   input  logic             MOSI,
   output logic             MISO,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             tx_underrun,
   output logic             frame_error
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE,
      ACTIVE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_d;
   logic                   ss_d;

   // The ss chain and its delayed copy reset to 1 (deselected).
   // If ss is already low when reset is released, the chain drains to 0.
   // That produces a fresh ss_fall, and a new frame starts from bit 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every stage take the previous
         // stage's old value, so the chain really is SYNC_STAGES flops deep.
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         ss_d      <= ss_sync[SYNC_STAGES-1];
      end
   end

   logic sclk_s;
   logic ss_s;
   logic mosi_s;
   logic sclk_rise;
   logic sclk_fall;
   logic ss_rise;
   logic ss_fall;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s &  sclk_d;
   assign ss_rise   =  ss_s   & ~ss_d;
   assign ss_fall   = ~ss_s   &  ss_d;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t           state;
   logic [CNT_W-1:0] bit_cnt;
   logic [WIDTH-1:0] shift_in;
   logic [WIDTH-1:0] shift_out;
   logic [WIDTH-1:0] tx_buf;
   logic             tx_full;

   // ---------------------------------------------------------------------------
   // Word-start load decision
   // ---------------------------------------------------------------------------
   // A new outgoing word is loaded when a frame opens.
   // It is also loaded on the sclk fall that follows a completed word.
   // An ss rise in the same cycle closes the frame instead, and nothing loads.
   logic             load_req;
   logic [WIDTH-1:0] load_word;

   always_comb begin
      // NOTE: every signal gets a default before any branch; without one,
      // an uncovered path would hold the old value and infer a latch.
      load_req  = 1'b0;
      load_word = IDLE_FILL;
      if (tx_full) begin
         load_word = tx_buf;
      end
      unique case (state)
         IDLE:    load_req = ss_fall;
         ACTIVE:  load_req = !ss_rise && sclk_fall && (bit_cnt == '0);
         default: load_req = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Transmit buffer
   // ---------------------------------------------------------------------------
   // A load empties a full buffer. A write is accepted only into an empty
   // buffer, so a write and a load in the same cycle never compete for one
   // word: either the load drains the old word (and the write is refused), or
   // the load takes IDLE_FILL and the new word stays buffered.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else begin
         if (load_req && tx_full) begin
            tx_full <= 1'b0;
         end
         if (tx_valid && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end
      end
   end

   assign tx_ready = !tx_full;

   // ---------------------------------------------------------------------------
   // Frame FSM, shift registers and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shift_in    <= '0;
         shift_out   <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         busy        <= 1'b0;
         MISO        <= 1'b0;
         tx_underrun <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         // Strobes are high for at most one cycle.
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         frame_error <= 1'b0;

         // Outgoing word: load at word start, otherwise shift on sclk fall.
         // MISO is registered alongside so it always shows the outgoing MSB.
         if (load_req) begin
            shift_out   <= load_word;
            MISO        <= load_word[WIDTH-1];
            tx_underrun <= !tx_full;
         end else if (state == ACTIVE && !ss_rise && sclk_fall) begin
            shift_out <= shift_out << 1;
            MISO      <= shift_out[WIDTH-2];
         end

         unique case (state)
            IDLE: begin
               if (ss_fall) begin
                  state   <= ACTIVE;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
               end
            end

            ACTIVE: begin
               if (ss_rise) begin
                  // ss rise beats a same-cycle sclk rise; the partial word is
                  // dropped and rx_data keeps its last complete value.
                  state   <= IDLE;
                  busy    <= 1'b0;
                  MISO    <= 1'b0;
                  bit_cnt <= '0;
                  if (bit_cnt != '0) begin
                     frame_error <= 1'b1;
                  end
               end else if (bit_cnt == CNT_FULL) begin
                  // The word completed on the previous cycle; publish it.
                  // The counter is back at 0 well before the next sclk fall.
                  rx_data  <= shift_in;
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
               end else if (sclk_rise) begin
                  shift_in <= {shift_in[WIDTH-2:0], mosi_s};
                  bit_cnt  <= bit_cnt + CNT_ONE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               MISO  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sync
//
// Self-checking bench for spi_slave_sync.
//
// A task-level SPI master drives sclk/ss/MOSI and collects MISO.
// The reference model works at the level of words:
//   - a one-word buffer (full flag + data);
//   - a queue of expected received words;
//   - expected counts of underrun and frame-error strobes.
// At each word start, the model decides what the master should receive.
// A separate monitor process pops expected rx words whenever rx_valid is seen,
// and counts the other strobes.
// -----------------------------------------------------------------------------
module tb_spi_slave_sync;

   localparam int          W    = 8;
   localparam int          SS_N = 2;
   localparam logic [7:0]  FILL = 8'hFF;

   logic       clock = 1'b0;
   logic       reset;
   logic       sclk;
   logic       ss;
   logic       mosi;
   logic       miso;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       tx_underrun;
   logic       frame_error;

   always #5 clock = ~clock;

   spi_slave_sync #(
      .WIDTH       (W),
      .SYNC_STAGES (SS_N),
      .IDLE_FILL   (FILL)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sclk        (sclk),
      .ss          (ss),
      .MOSI        (mosi),
      .MISO        (miso),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .busy        (busy),
      .tx_underrun (tx_underrun),
      .frame_error (frame_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   bit         m_full     = 1'b0;
   logic [7:0] m_buf      = '0;
   logic [7:0] m_last_rx  = '0;
   int         exp_underrun  = 0;
   int         exp_ferr      = 0;
   int         seen_underrun = 0;
   int         seen_ferr     = 0;
   logic [7:0] exp_rx[$];

   // Word start: take the buffered word, or send the idle fill and note an underrun.
   function automatic logic [7:0] model_load();
      if (m_full) begin
         m_full = 1'b0;
         return m_buf;
      end
      exp_underrun++;
      return FILL;
   endfunction

   // ---------------------------------------------------------------------------
   // Monitor: compares published words, counts strobes
   // ---------------------------------------------------------------------------
   always @(negedge clock) begin
      if (rx_valid) begin
         if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
         else                    check("rx_data", rx_data, exp_rx.pop_front());
      end
      if (tx_underrun) seen_underrun++;
      if (frame_error) seen_ferr++;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change on the falling clock edge)
   // ---------------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic tx_write(input logic [7:0] d);
      check("tx_ready_before_write", tx_ready, !m_full);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
      if (!m_full) begin
         m_full = 1'b1;
         m_buf  = d;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(3);
      reset     = 1'b0;
      m_full    = 1'b0;
      m_last_rx = '0;
   endtask

   // One ss frame of nwords words.
   // The last word carries last_bits bits; fewer than W means an aborted word.
   // When wr_en is set, wr_data is offered at bit 3 of word wr_word.
   // The final sclk fall coincides with ss rising.
   task automatic run_frame(input logic [7:0] words[4], input int nwords,
                            input int last_bits, input int half,
                            input bit wr_en, input int wr_word,
                            input logic [7:0] wr_data);
      logic [7:0] exp_m;
      logic [7:0] got;
      int         nb;
      ss = 1'b0;
      for (int w = 0; w < nwords; w++) begin
         nb    = (w == nwords - 1) ? last_bits : W;
         exp_m = model_load();
         if (nb == W) begin
            exp_rx.push_back(words[w]);
            m_last_rx = words[w];
         end
         if (w == 0) begin
            cyc(SS_N + 3);
            check("busy_in_frame", busy, 1'b1);
            check("tx_ready_after_load", tx_ready, !m_full);
         end
         got = '0;
         for (int b = 0; b < nb; b++) begin
            mosi = words[w][W-1-b];
            cyc(half);
            sclk = 1'b1;
            got  = {got[6:0], miso};
            if (wr_en && w == wr_word && b == 3) begin
               tx_write(wr_data);
               cyc(half - 1);
            end else begin
               cyc(half);
            end
            sclk = 1'b0;
            if (w == nwords - 1 && b == nb - 1) ss = 1'b1;
         end
         if (nb == W) check("miso_word", got, exp_m);
         else         check("miso_partial", got, exp_m >> (W - nb));
         if (nb != W) exp_ferr++;
      end
      ss = 1'b1;
      cyc(6);
      check("busy_after_frame", busy, 1'b0);
      check("miso_idle", miso, 1'b0);
   endtask

   task automatic end_test(input string name);
      cyc(4);
      check({name, "_underruns"}, seen_underrun, exp_underrun);
      check({name, "_frame_errors"}, seen_ferr, exp_ferr);
      check({name, "_rx_pending"}, exp_rx.size(), 0);
      check({name, "_rx_hold"}, rx_data, m_last_rx);
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   logic [7:0] fw[4];
   logic [7:0] got3;
   logic [7:0] abort_m;

   initial begin
      reset    = 1'b1;
      sclk     = 1'b0;
      ss       = 1'b1;
      mosi     = 1'b0;
      tx_data  = '0;
      tx_valid = 1'b0;
      do_reset();

      // 1: idle after reset
      cyc(10);
      check("reset_miso", miso, 1'b0);
      check("reset_tx_ready", tx_ready, 1'b1);
      check("reset_busy", busy, 1'b0);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_valid", rx_valid, 1'b0);
      check("reset_underrun", tx_underrun, 1'b0);
      check("reset_frame_error", frame_error, 1'b0);
      end_test("t1");

      // 2: single word exchange
      tx_write(8'h3C);
      fw = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame(fw, 1, W, 5, 1'b0, 0, 8'h00);
      end_test("t2");

      // 3: two back-to-back words; second tx word written during word 1
      tx_write(8'h6D);
      fw = '{8'h01, 8'h02, 8'h00, 8'h00};
      run_frame(fw, 2, W, 4, 1'b1, 0, 8'h91);
      end_test("t3");

      // 4: empty buffer at frame start
      fw = '{8'hC8, 8'h00, 8'h00, 8'h00};
      run_frame(fw, 1, W, 6, 1'b0, 0, 8'h00);
      end_test("t4");

      // 5: frame dropped after 5 bits, then a normal frame
      tx_write(8'h5E);
      fw = '{8'h9A, 8'h00, 8'h00, 8'h00};
      run_frame(fw, 1, 5, 5, 1'b0, 0, 8'h00);
      end_test("t5a");
      tx_write(8'hB4);
      fw = '{8'h2F, 8'h00, 8'h00, 8'h00};
      run_frame(fw, 1, W, 5, 1'b0, 0, 8'h00);
      end_test("t5b");

      // 6: reset after 3 bits, released with ss still low
      tx_write(8'hC3);
      ss      = 1'b0;
      abort_m = model_load();
      cyc(SS_N + 3);
      got3 = '0;
      for (int b = 0; b < 3; b++) begin
         mosi = b[0];
         cyc(5);
         sclk = 1'b1;
         got3 = {got3[6:0], miso};
         cyc(5);
         sclk = 1'b0;
      end
      check("t6_miso_partial", got3, abort_m >> (W - 3));
      cyc(2);
      reset = 1'b1;
      cyc(1);
      check("t6_busy_in_reset", busy, 1'b0);
      check("t6_tx_ready_in_reset", tx_ready, 1'b1);
      cyc(2);
      m_full    = 1'b0;
      m_last_rx = '0;
      // Offer a word on the first cycle out of reset.
      // The responder then sees ss low through its preset synchronizer as a
      // new frame start, and that load takes the word.
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      reset    = 1'b0;
      @(negedge clock);
      tx_valid = 1'b0;
      m_full   = 1'b1;
      m_buf    = 8'h5A;
      void'(model_load());
      cyc(6);
      check("t6_busy_reopened", busy, 1'b1);
      ss = 1'b1;
      cyc(6);
      check("t6_busy_closed", busy, 1'b0);
      tx_write(8'h77);
      tx_write(8'hEE);
      fw = '{8'h4B, 8'h00, 8'h00, 8'h00};
      run_frame(fw, 1, W, 5, 1'b0, 0, 8'h00);
      end_test("t6");

      // Randomized frames
      for (int i = 0; i < 12; i++) begin
         int  nw;
         int  lb;
         int  hp;
         bit  we;
         nw = $urandom_range(1, 3);
         hp = $urandom_range(4, 8);
         lb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W;
         we = $urandom_range(0, 1) == 1;
         for (int k = 0; k < 4; k++) fw[k] = 8'($urandom);
         if ($urandom_range(0, 2) != 0) tx_write(8'($urandom));
         run_frame(fw, nw, lb, hp, we, $urandom_range(0, nw - 1), 8'($urandom));
         end_test("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
